// File: rtl/useq_address.sv
// Microsequencer address register: picks next control-store address (inc/jump/decode/cond/call/return/hold).
// Latency: new address registered one cycle after the sequencing type is presented.
// Backpressure: USEQ_Stall_In freezes address, return stack, level and sticky errors.
module useq_address #(
  parameter int DATAWIDTH_CSADDRESS = 11,
  parameter int DATAWIDTH_OPS       = 8,
  parameter int DATAWIDTH_FLAGS     = 8,
  parameter int DATAWIDTH_CSEL      = 3,
  parameter int STACK_DEPTH         = 4
) (
  input  logic                                 USEQ_CLOCK_50,
  input  logic                                 USEQ_ResetInHigh_In,
  input  logic [2:0]                           USEQ_Tipo_InBus,
  input  logic [DATAWIDTH_CSADDRESS-1:0]       USEQ_JumpAddress_InBus,
  input  logic [DATAWIDTH_OPS-1:0]             USEQ_DecodeOp_InBus,
  input  logic [DATAWIDTH_FLAGS-1:0]           USEQ_Flags_InBus,
  input  logic [DATAWIDTH_CSEL-1:0]            USEQ_CondSel_InBus,
  input  logic                                 USEQ_CondInvert_In,
  input  logic                                 USEQ_Stall_In,
  input  logic                                 USEQ_ErrClear_In,
  output logic [DATAWIDTH_CSADDRESS-1:0]       USEQ_CSAddress_OutBus,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     USEQ_StackLevel_OutBus,
  output logic                                 USEQ_Overflow_Out,
  output logic                                 USEQ_Underflow_Out
);

  localparam int CSW     = DATAWIDTH_CSADDRESS;
  localparam int LVLW    = $clog2(STACK_DEPTH + 1);
  localparam int IDXW    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int DEC_PAD = DATAWIDTH_OPS - 3;
  localparam logic [LVLW-1:0] LVL_FULL = LVLW'(STACK_DEPTH);

  // Sequencing types carried in the microword
  typedef enum logic [2:0] {
    SEQ_NEXT   = 3'b000,
    SEQ_JUMP   = 3'b001,
    SEQ_DECODE = 3'b010,
    SEQ_CJUMP  = 3'b011,
    SEQ_CALL   = 3'b100,
    SEQ_RETURN = 3'b101,
    SEQ_CCALL  = 3'b110,
    SEQ_HOLD   = 3'b111
  } seq_t;

  logic [CSW-1:0]  addr_q, addr_d;
  logic [CSW-1:0]  inc_addr;
  logic [CSW-1:0]  dec_addr;
  logic [CSW-1:0]  stack_top;
  logic [LVLW-1:0] level_q, level_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            cond_flag;
  logic            cond;
  logic            do_call;
  logic            push_en;
  logic            ovf_set;
  logic            unf_set;
  logic            stack_full;
  logic            stack_empty;
  logic [IDXW-1:0] wr_idx;
  logic [IDXW-1:0] rd_idx;
  seq_t            tipo;

  // Return addresses; contents survive reset, only the level is cleared
  logic [CSW-1:0]  stack_mem [STACK_DEPTH];

  assign tipo        = seq_t'(USEQ_Tipo_InBus);
  assign inc_addr    = addr_q + 1'b1;
  assign stack_full  = (level_q == LVL_FULL);
  assign stack_empty = (level_q == '0);
  assign wr_idx      = IDXW'(level_q);
  assign rd_idx      = IDXW'(level_q - 1'b1);
  assign stack_top   = stack_mem[rd_idx];

  // Flag selection; indices past the flag bus read as zero before inversion
  always_comb begin
    cond_flag = 1'b0;
    if (int'(USEQ_CondSel_InBus) < DATAWIDTH_FLAGS) begin
      cond_flag = USEQ_Flags_InBus[USEQ_CondSel_InBus];
    end
    cond = cond_flag ^ USEQ_CondInvert_In;
  end

  // Opcode map: top two opcode bits zero selects a 32-word spaced table, else 4-word spaced
  always_comb begin
    if (USEQ_DecodeOp_InBus[DATAWIDTH_OPS-1 -: 2] == 2'b00) begin
      dec_addr = {1'b1, USEQ_DecodeOp_InBus[DATAWIDTH_OPS-1 -: 5], {DEC_PAD{1'b0}}};
    end else begin
      dec_addr = {1'b1, USEQ_DecodeOp_InBus, 2'b00};
    end
  end

  // Next address, stack level and error-set decisions for this cycle
  always_comb begin
    addr_d  = addr_q;
    level_d = level_q;
    do_call = 1'b0;
    push_en = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;

    case (tipo)
      SEQ_NEXT:   addr_d = inc_addr;
      SEQ_JUMP:   addr_d = USEQ_JumpAddress_InBus;
      SEQ_DECODE: addr_d = dec_addr;
      SEQ_CJUMP:  addr_d = cond ? USEQ_JumpAddress_InBus : inc_addr;
      SEQ_CALL:   do_call = 1'b1;
      SEQ_RETURN: begin
        if (stack_empty) begin
          // Nothing to return to: fall through and flag it
          addr_d  = inc_addr;
          unf_set = 1'b1;
        end else begin
          addr_d  = stack_top;
          level_d = level_q - 1'b1;
        end
      end
      SEQ_CCALL: begin
        if (cond) begin
          do_call = 1'b1;
        end else begin
          addr_d = inc_addr;
        end
      end
      SEQ_HOLD:   addr_d = addr_q;
      default:    addr_d = addr_q;
    endcase

    // The jump of a call is always taken; only the push is lost when full
    if (do_call) begin
      addr_d = USEQ_JumpAddress_InBus;
      if (stack_full) begin
        ovf_set = 1'b1;
      end else begin
        push_en = 1'b1;
        level_d = level_q + 1'b1;
      end
    end

    // A new error in the same cycle beats a clear request
    ovf_d = ovf_set | (ovf_q & ~USEQ_ErrClear_In);
    unf_d = unf_set | (unf_q & ~USEQ_ErrClear_In);
  end

  // Address, level and sticky error registers with reset over stall
  always_ff @(posedge USEQ_CLOCK_50) begin
    if (USEQ_ResetInHigh_In) begin
      addr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (!USEQ_Stall_In) begin
      addr_q  <= addr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Return-address push of the caller's successor
  always_ff @(posedge USEQ_CLOCK_50) begin
    if (!USEQ_ResetInHigh_In && !USEQ_Stall_In && push_en) begin
      stack_mem[wr_idx] <= inc_addr;
    end
  end

  assign USEQ_CSAddress_OutBus  = addr_q;
  assign USEQ_StackLevel_OutBus = level_q;
  assign USEQ_Overflow_Out      = ovf_q;
  assign USEQ_Underflow_Out     = unf_q;

endmodule
